// File: rtl/scroll_pkg.sv
// scroll_pkg: shared symbol, digit-count and FSM state types for the symbol scroller
package scroll_pkg;
    typedef logic [2:0] sym_t;
    localparam sym_t SYM_F = 3'b000;
    localparam sym_t SYM_L = 3'b001;
    localparam sym_t SYM_I = 3'b011;
    localparam int NUM_DIGITS = 6;
    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
endpackage

// File: rtl/symbol_scroller_if.sv
// symbol_scroller_if: control inputs and digit/status outputs of the symbol scroller
interface symbol_scroller_if;
    import scroll_pkg::*;
    logic start_i, stop_i, pause_i, dir_i, one_shot_i;
    logic [3*NUM_DIGITS-1:0] digits_o;
    logic busy_o, wrap_o;
    modport master (
        output start_i, stop_i, pause_i, dir_i, one_shot_i,
        input digits_o, busy_o, wrap_o
    );
    modport slave (
        input start_i, stop_i, pause_i, dir_i, one_shot_i,
        output digits_o, busy_o, wrap_o
    );
endinterface

// File: rtl/tick_prescaler.sv
// tick_prescaler: wrapping counter flagging the last cycle of each TICK_DIV interval
module tick_prescaler #(
    parameter int TICK_DIV = 25000000
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_o
);
    localparam int W = $clog2(TICK_DIV);
    localparam logic [W-1:0] TC = W'(TICK_DIV - 1);
    logic [W-1:0] cnt;
    assign tick_o = cnt == TC;
    always_ff @(posedge clk_i) begin
        if (!rst_n_i || clr_i)
            cnt <= '0;
        else if (en_i)
            cnt <= tick_o ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/symbol_scroller.sv
// symbol_scroller: scrolls a six-digit window of 3-bit symbol codes through a short message
module symbol_scroller
    import scroll_pkg::*;
#(
    parameter int TICK_DIV = 25000000,
    parameter int MSG_LEN = 8,
    parameter logic [23:0] MSG = 24'o31031031
) (
    input logic clk_i,
    input logic rst_n_i,
    symbol_scroller_if.slave bus
);
    localparam logic [2:0] LAST = 3'(MSG_LEN - 1);
    state_t state;
    logic [2:0] pos, pos_next;
    logic tick, run_en, step, wraps, busy, wrap;
    logic [2:0] idx [NUM_DIGITS];
    sym_t [NUM_DIGITS-1:0] digits;
    assign run_en = state == RUN && !bus.stop_i && !bus.pause_i;
    assign step = run_en && tick;
    assign wraps = bus.dir_i ? pos == '0 : pos == LAST;
    assign pos_next = bus.dir_i ? (pos == '0 ? LAST : pos - 3'd1) : (pos == LAST ? '0 : pos + 3'd1);
    assign bus.busy_o = busy;
    assign bus.wrap_o = wrap;
    assign bus.digits_o = digits;
    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clr_i   (state == IDLE || bus.stop_i),
        .en_i    (run_en),
        .tick_o  (tick)
    );
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state <= IDLE;
            pos <= '0;
            busy <= 1'b0;
            wrap <= 1'b0;
        end else begin
            wrap <= step && wraps;
            if (step)
                pos <= pos_next;
            case (state)
                IDLE: if (bus.start_i && !bus.stop_i) begin
                    state <= RUN;
                    busy <= 1'b1;
                end
                RUN: if (bus.stop_i || (step && wraps && bus.one_shot_i)) begin
                    state <= IDLE;
                    busy <= 1'b0;
                end else if (bus.pause_i)
                    state <= HOLD;
                HOLD: if (bus.stop_i) begin
                    state <= IDLE;
                    busy <= 1'b0;
                end else if (!bus.pause_i)
                    state <= RUN;
                default: begin
                    state <= IDLE;
                    busy <= 1'b0;
                end
            endcase
        end
    end
    // each digit index is the previous one plus one, folded back by a single compare-and-subtract
    assign idx[0] = pos;
    for (genvar k = 1; k < NUM_DIGITS; k++) begin : g_idx
        logic [3:0] s;
        assign s = {1'b0, idx[k-1]} + 4'd1;
        assign idx[k] = 3'(s >= 4'(MSG_LEN) ? s - 4'(MSG_LEN) : s);
    end
    always_comb begin
        digits = '0;
        for (int k = 0; k < NUM_DIGITS; k++)
            digits[k] = MSG[3*idx[k] +: 3];
    end
endmodule

// File: tb/tb_symbol_scroller.sv
// tb_symbol_scroller: directed and random stimulus against a cycle-level behavioural model
module tb_symbol_scroller;
    import scroll_pkg::*;
    localparam int TD = 4;
    localparam int L = 5;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    symbol_scroller_if bus();
    symbol_scroller #(.TICK_DIV(TD), .MSG_LEN(L), .MSG(24'o00010310)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );
    always #5 clk = ~clk;
    sym_t msg [L] = '{SYM_F, SYM_L, SYM_I, SYM_F, SYM_L};
    int checks = 0;
    int fails = 0;
    int st = 0;
    int pos = 0;
    int rem = TD;
    logic wrap = 1'b0;
    int saved;

    function automatic logic [17:0] window(int p);
        logic [17:0] w;
        for (int k = 0; k < 6; k++)
            w[3*k +: 3] = msg[(p + k) % L];
        return w;
    endfunction

    task automatic check(string tag, logic [17:0] obs, logic [17:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // st: 0 idle, 1 running, 2 held; rem counts cycles left until the next step
    task automatic cyc(logic r, logic start, logic stop, logic pause, logic dir, logic os);
        rst_n = r;
        bus.start_i = start;
        bus.stop_i = stop;
        bus.pause_i = pause;
        bus.dir_i = dir;
        bus.one_shot_i = os;
        @(posedge clk);
        wrap = 1'b0;
        if (!r) begin
            st = 0; pos = 0; rem = TD;
        end else if (st == 0) begin
            rem = TD;
            if (start && !stop) st = 1;
        end else if (stop) begin
            st = 0; rem = TD;
        end else if (pause) begin
            st = 2;
        end else if (st == 2) begin
            st = 1;
        end else begin
            rem--;
            if (rem == 0) begin
                rem = TD;
                if (dir) begin
                    wrap = pos == 0;
                    pos = (pos + L - 1) % L;
                end else begin
                    pos = (pos + 1) % L;
                    wrap = pos == 0;
                end
                if (wrap && os) st = 0;
            end
        end
        #1;
        check("digits", bus.digits_o, window(pos));
        check("busy", 18'(bus.busy_o), 18'(st != 0));
        check("wrap", 18'(bus.wrap_o), 18'(wrap));
    endtask

    initial begin
        bus.start_i = 0; bus.stop_i = 0; bus.pause_i = 0; bus.dir_i = 0; bus.one_shot_i = 0;
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        check("reset_window", bus.digits_o, 18'o010310);
        repeat (20) cyc(1, 0, 0, 0, 0, 0);
        check("idle_window", bus.digits_o, 18'o010310);
        cyc(1, 1, 0, 0, 0, 0);
        repeat (22) cyc(1, 0, 0, 0, 0, 0);
        repeat (8) cyc(1, 0, 0, 0, 1, 0);
        for (int i = 0; i < 8 && rem != TD - 2; i++) cyc(1, 0, 0, 0, 0, 0);
        saved = pos;
        repeat (10) cyc(1, 0, 0, 1, 0, 0);
        check("pause_hold_pos", bus.digits_o, window(saved));
        repeat (6) cyc(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 40 && pos != 3; i++) cyc(1, 0, 0, 0, 0, 0);
        repeat (12) cyc(1, 0, 0, 0, 0, 1);
        check("one_shot_idle", 18'(bus.busy_o), 18'd0);
        check("one_shot_pos0", bus.digits_o, 18'o010310);
        repeat (6) cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 40 && !(rem == 1 && pos == L - 1); i++) cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        check("stop_rst_wrap", 18'(bus.wrap_o), 18'd0);
        check("stop_rst_window", bus.digits_o, 18'o010310);
        cyc(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 40 && !(rem == 1 && pos == 2); i++) cyc(1, 0, 0, 0, 0, 0);
        saved = pos;
        cyc(1, 0, 1, 0, 0, 0);
        check("stop_tc_pos", bus.digits_o, window(saved));
        check("stop_tc_busy", 18'(bus.busy_o), 18'd0);
        repeat (3000)
            cyc($urandom_range(0, 199) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
                $urandom_range(0, 5) == 0, 1'($urandom), $urandom_range(0, 3) == 0);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
